// File: rtl/sbus_rb_loader.sv
// sbus_rb_loader: takes framed address+data words from a single-bit serial
// link, writes each word into an external register bank and checks the write
// by reading it back.
//
// Frame: address MSB first, then data MSB first, one bit per rising clk edge
// while sen is low. Frames may follow each other with no gap.
// Optional macro SBUS_PARITY_EN: adds one even-parity bit after the data.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   sen        serial enable, active low
//   sd         serial data, MSB first
//   rb_q       bank read data, valid one cycle after a read address
//   rb_rw      1 = read, 0 = write (low for exactly one cycle per write)
//   rb_a       bank address
//   rb_d       bank write data (held until the next write)
//   frame_cnt  frames written, saturating
//   done       sticky: NUM_FRAMES written and the last read-back matched
//   vfy_err    sticky: a read-back mismatched
//   frm_err    sticky: sen rose mid-frame
//   par_err    sticky: parity failure (constant 0 without SBUS_PARITY_EN)
module sbus_rb_loader #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  input  logic [DATA_W-1:0] rb_q,
  output logic              rb_rw,
  output logic [ADDR_W-1:0] rb_a,
  output logic [DATA_W-1:0] rb_d,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              done,
  output logic              vfy_err,
  output logic              frm_err,
  output logic              par_err
);

`ifdef SBUS_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned FL   = ADDR_W + DATA_W + PAR_W;
  localparam int unsigned BC_W = $clog2(FL);

  typedef enum logic [1:0] {
    RX_ADDR = 2'd0,
    RX_DATA = 2'd1,
    RX_PAR  = 2'd2
  } rx_state_e;

  // State that carries the final bit of a frame.
  localparam rx_state_e LAST_ST = (PAR_W != 0) ? RX_PAR : RX_DATA;

  rx_state_e          state_q, state_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FL-2:0]      shift_q, shift_d;
  logic               rb_rw_q, rb_rw_d;
  logic [ADDR_W-1:0]  rb_a_q, rb_a_d;
  logic [DATA_W-1:0]  rb_d_q, rb_d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               vfy_err_q, vfy_err_d;
  logic               frm_err_q, frm_err_d;
  logic               par_err_q, par_err_d;
  // Verify pipeline: l1 travels with the write cycle, v2/l2 mark the read
  // cycle, v3/l3 mark the cycle whose closing edge compares rb_q.
  logic               l1_q, l1_d;
  logic               v2_q, v2_d, l2_q, l2_d;
  logic               v3_q, v3_d, l3_q, l3_d;

  logic [FL-1:0]      frame_w;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic               last_bit;
  logic               par_ok;
  logic               cnt_sat;

  // Frame as it stands including the bit being sampled this edge.
  always_comb begin
    frame_w    = {shift_q, sd};
    frame_addr = frame_w[FL-1 -: ADDR_W];
    frame_data = frame_w[FL-1-ADDR_W -: DATA_W];
    last_bit   = !sen && (state_q == LAST_ST) && (bit_cnt_q == BC_W'(FL-1));
    cnt_sat    = &cnt_q;
`ifdef SBUS_PARITY_EN
    par_ok     = ~^frame_w;
`else
    par_ok     = 1'b1;
`endif
  end

  // Next-state: receive FSM, write/verify pipeline and sticky flags.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rb_rw_d   = 1'b1;
    rb_a_d    = rb_a_q;
    rb_d_d    = rb_d_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    vfy_err_d = vfy_err_q;
    frm_err_d = frm_err_q;
    par_err_d = par_err_q;
    l1_d      = 1'b0;
    v2_d      = !rb_rw_q;
    l2_d      = l1_q;
    v3_d      = v2_q;
    l3_d      = l2_q;

    if (sen) begin
      // Enable released: an unfinished frame is dropped and flagged.
      state_d   = RX_ADDR;
      bit_cnt_d = '0;
      if (bit_cnt_q != '0) frm_err_d = 1'b1;
    end else begin
      shift_d = frame_w[FL-2:0];
      unique case (state_q)
        RX_ADDR: if (bit_cnt_q == BC_W'(ADDR_W-1)) state_d = RX_DATA;
        RX_DATA: if (bit_cnt_q == BC_W'(ADDR_W+DATA_W-1))
                   state_d = (PAR_W != 0) ? RX_PAR : RX_ADDR;
        RX_PAR:  state_d = RX_ADDR;
        default: state_d = RX_ADDR;
      endcase
      if (last_bit) begin
        bit_cnt_d = '0;
        if (!par_ok) begin
          par_err_d = 1'b1;
        end else if (!done_q) begin
          rb_rw_d = 1'b0;
          rb_a_d  = frame_addr;
          rb_d_d  = frame_data;
          l1_d    = !cnt_sat && ((cnt_q + CNT_W'(1)) == CNT_W'(NUM_FRAMES));
          if (!cnt_sat) cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
    end

    // rb_d_q still holds the verified word here even if a new write is
    // being launched on this same edge.
    if (v3_q) begin
      if (rb_q != rb_d_q) vfy_err_d = 1'b1;
      else if (l3_q)      done_d    = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_ADDR;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rb_rw_q   <= 1'b1;
      rb_a_q    <= '0;
      rb_d_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      vfy_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      par_err_q <= 1'b0;
      l1_q      <= 1'b0;
      v2_q      <= 1'b0;
      l2_q      <= 1'b0;
      v3_q      <= 1'b0;
      l3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rb_rw_q   <= rb_rw_d;
      rb_a_q    <= rb_a_d;
      rb_d_q    <= rb_d_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      vfy_err_q <= vfy_err_d;
      frm_err_q <= frm_err_d;
      par_err_q <= par_err_d;
      l1_q      <= l1_d;
      v2_q      <= v2_d;
      l2_q      <= l2_d;
      v3_q      <= v3_d;
      l3_q      <= l3_d;
    end
  end

  assign rb_rw     = rb_rw_q;
  assign rb_a      = rb_a_q;
  assign rb_d      = rb_d_q;
  assign frame_cnt = cnt_q;
  assign done      = done_q;
  assign vfy_err   = vfy_err_q;
  assign frm_err   = frm_err_q;
`ifdef SBUS_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sbus_rb_loader.sv
// Bench for sbus_rb_loader: directed frames, a register-bank model with an
// optional corrupted address, a frame-level reference model and per-cycle
// output comparison plus hand-computed literal checks.
module tb_sbus_rb_loader;

`ifdef SBUS_PARITY_EN
  localparam int FL = 22;
`else
  localparam int FL = 21;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sen = 1'b1;
  logic        sd  = 1'b0;
  logic [17:0] rb_q;
  logic        rb_rw;
  logic [2:0]  rb_a;
  logic [17:0] rb_d;
  logic [7:0]  frame_cnt;
  logic        done, vfy_err, frm_err, par_err;

  sbus_rb_loader dut (
    .clk(clk), .rst(rst), .sen(sen), .sd(sd), .rb_q(rb_q),
    .rb_rw(rb_rw), .rb_a(rb_a), .rb_d(rb_d), .frame_cnt(frame_cnt),
    .done(done), .vfy_err(vfy_err), .frm_err(frm_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Register bank: write on rb_rw=0, registered read otherwise.
  logic [17:0] mem [8];
  bit          corrupt = 1'b0;
  initial for (int i = 0; i < 8; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (rb_rw === 1'b0) mem[rb_a] <= rb_d;
    else rb_q <= mem[rb_a] ^ {17'b0, (corrupt && rb_a == 3'd2)};
  end

  // Reference model: frames assembled from the bit stream; each accepted
  // frame is a one-cycle write, and its read-back verdict arrives 3 edges later.
  typedef struct { int due; bit last; bit bad; } pend_t;
  bit    bq[$];
  pend_t pend[$];
  int    e = 0;
  bit    chk_en = 1'b0;
  int    x_rw, x_a, x_d, x_cnt, x_done, x_vfy, x_frm, x_par;

  always @(posedge clk) begin
    e++;
    if (rst) begin
      bq.delete(); pend.delete();
      x_rw = 1; x_a = 0; x_d = 0; x_cnt = 0;
      x_done = 0; x_vfy = 0; x_frm = 0; x_par = 0;
      chk_en = 1'b1;
    end else begin
      x_rw = 1;
      if (!sen) begin
        bq.push_back(sd);
        if (bq.size() == FL) begin
          logic [FL-1:0] fw;
          fw = '0;
          foreach (bq[i]) fw = {fw[FL-2:0], bq[i]};
          bq.delete();
          if (^fw !== 1'b0 && FL == 22) x_par = 1;
          else if (x_done == 0) begin
            pend_t p;
            x_rw = 0;
            x_a  = int'(fw[FL-1 -: 3]);
            x_d  = int'(fw[FL-4 -: 18]);
            p.due  = e + 3;
            p.last = (x_cnt < 255) && (x_cnt + 1 == 8);
            p.bad  = corrupt && (x_a == 2);
            pend.push_back(p);
            if (x_cnt < 255) x_cnt++;
          end
        end
      end else if (bq.size() != 0) begin
        x_frm = 1;
        bq.delete();
      end
      while (pend.size() != 0 && pend[0].due == e) begin
        if (pend[0].bad) x_vfy = 1;
        else if (pend[0].last) x_done = 1;
        void'(pend.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rb_rw",     32'(rb_rw),     32'(x_rw));
      chk("rb_a",      32'(rb_a),      32'(x_a));
      chk("rb_d",      32'(rb_d),      32'(x_d));
      chk("frame_cnt", 32'(frame_cnt), 32'(x_cnt));
      chk("done",      32'(done),      32'(x_done));
      chk("vfy_err",   32'(vfy_err),   32'(x_vfy));
      chk("frm_err",   32'(frm_err),   32'(x_frm));
      chk("par_err",   32'(par_err),   32'(x_par));
    end
  end

  // Write monitor for literal checks.
  int          w_count = 0;
  int          w_first = 0;
  int          w_last  = 0;
  logic [2:0]  w_a;
  logic [17:0] w_d;
  always @(posedge clk) begin
    #1;
    if (rb_rw === 1'b0) begin
      if (w_count == 0) w_first = e;
      w_last = e;
      w_a = rb_a;
      w_d = rb_d;
      w_count++;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; sen = 1'b1;
    @(negedge clk); rst = 1'b0;
    w_count = 0;
  endtask

  task automatic send_bits(input logic [2:0] a, input logic [17:0] d,
                           input bit bad_par, input int nbits);
    logic [FL-1:0] fw;
`ifdef SBUS_PARITY_EN
    fw = {a, d, (^{a, d}) ^ bad_par};
`else
    fw = {a, d};
    if (bad_par) fw = {a, d};
`endif
    for (int i = FL - 1; i >= FL - nbits; i--) begin
      @(negedge clk); sen = 1'b0; sd = fw[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); sen = 1'b1; sd = 1'b0;
    end
  endtask

  initial begin
    // Single frame.
    do_reset();
    chk("reset_rw", 32'(rb_rw), 32'd1);
    chk("reset_cnt", 32'(frame_cnt), 32'd0);
    send_bits(3'd5, 18'h2A5C3, 1'b0, FL);
    idle(6);
    chk("A_writes", 32'(w_count), 32'd1);
    chk("A_addr", 32'(w_a), 32'd5);
    chk("A_data", 32'(w_d), 32'h2A5C3);
    chk("A_cnt", 32'(frame_cnt), 32'd1);
    chk("A_vfy", 32'(vfy_err), 32'd0);
    chk("A_done", 32'(done), 32'd0);

    // Eight back-to-back frames.
    do_reset();
    for (int i = 0; i < 8; i++) send_bits(3'(i), 18'(i * 18'h1111), 1'b0, FL);
    idle(6);
    chk("B_writes", 32'(w_count), 32'd8);
    chk("B_spacing", 32'(w_last - w_first), 32'(7 * FL));
    chk("B_last_d", 32'(w_d), 32'h07777);
    chk("B_cnt", 32'(frame_cnt), 32'd8);
    chk("B_done", 32'(done), 32'd1);

    // Short frame then a good one.
    do_reset();
    send_bits(3'd6, 18'h3FFFF, 1'b0, 10);
    idle(3);
    chk("C_frm", 32'(frm_err), 32'd1);
    chk("C_nowrite", 32'(w_count), 32'd0);
    send_bits(3'd6, 18'h3FFFF, 1'b0, FL);
    idle(5);
    chk("C_writes", 32'(w_count), 32'd1);
    chk("C_cnt", 32'(frame_cnt), 32'd1);

    // Corrupted read-back at address 2, then a frame after done.
    do_reset();
    corrupt = 1'b1;
    for (int i = 0; i < 8; i++) send_bits(3'(i), 18'(i * 18'h1111), 1'b0, FL);
    idle(6);
    chk("D_vfy", 32'(vfy_err), 32'd1);
    chk("D_done", 32'(done), 32'd1);
    send_bits(3'd4, 18'h12345, 1'b0, FL);
    idle(6);
    chk("D_after_done_writes", 32'(w_count), 32'd8);
    chk("D_after_done_cnt", 32'(frame_cnt), 32'd8);
    corrupt = 1'b0;

    // Reset in the middle of a frame.
    send_bits(3'd3, 18'h0ABCD, 1'b0, 7);
    @(negedge clk); rst = 1'b1; sen = 1'b0; sd = 1'b1;
    @(negedge clk);
    chk("R_rw", 32'(rb_rw), 32'd1);
    chk("R_a", 32'(rb_a), 32'd0);
    chk("R_d", 32'(rb_d), 32'd0);
    chk("R_cnt", 32'(frame_cnt), 32'd0);
    chk("R_flags", 32'({done, vfy_err, frm_err, par_err}), 32'd0);
    rst = 1'b0; sen = 1'b1;
    idle(4);

`ifdef SBUS_PARITY_EN
    // Bad parity then good parity.
    do_reset();
    send_bits(3'd1, 18'd1, 1'b1, FL);
    idle(5);
    chk("P_par", 32'(par_err), 32'd1);
    chk("P_nowrite", 32'(w_count), 32'd0);
    send_bits(3'd1, 18'd1, 1'b0, FL);
    idle(5);
    chk("P_writes", 32'(w_count), 32'd1);
    chk("P_cnt", 32'(frame_cnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sbus_rb_loader.md
Name: sbus_rb_loader

Overview:
- Serial-to-register-bank loader: deserialises framed address+data words from a single-bit serial link and writes each word into an external register bank.
- Each write is verified by read-back.
- Parametrised successor of the fixed 3-bit-address / 18-bit-data / 8-word loader.
- Adds:
  - configurable widths and frame count
  - back-to-back frames
  - short-frame detection
  - read-back mismatch flagging
  - a written-word counter

Parameters:
- ADDR_W, 3, address bits per frame; bank depth is 2**ADDR_W.
- DATA_W, 18, data bits per frame.
- NUM_FRAMES, 8, good writes required before done asserts (1..2**ADDR_W+... any value up to 255).
- CNT_W, 8, width of frame_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- sen  in  1  serial enable, active low; frame bits valid while 0.
- sd  in  1  serial data, MSB first, sampled on clk rise while sen=0.
- rb_q  in  DATA_W  register-bank read data; valid one cycle after rb_a is presented with rb_rw=1.
- rb_rw  out  1  1=read, 0=write.
- rb_a  out  ADDR_W  register-bank address.
- rb_d  out  DATA_W  register-bank write data.
- frame_cnt  out  CNT_W  count of frames written, saturating at all-ones.
- done  out  1  sticky; NUM_FRAMES writes completed and last read-back matched.
- vfy_err  out  1  sticky; a read-back mismatched.
- frm_err  out  1  sticky; sen rose mid-frame.
- par_err  out  1  sticky parity error (see optional feature; tied 0 otherwise).

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - rb_rw=1; rb_a=0; rb_d=0; frame_cnt=0.
  - done, vfy_err, frm_err, par_err = 0.
  - Bit counter=0; pipeline stages invalid.
  - Reset mid-frame discards the partial frame; reset overrides all same-cycle events.
- Frame format:
  - FL = ADDR_W+DATA_W bits (+1 with parity).
  - Address MSB first, then data MSB first, as seen on consecutive clk edges with sen=0.
  - No gap is needed between frames: if sen stays low, the bit after the last bit of frame n is bit 0 of frame n+1.
- Receive logic:
  - States RX_ADDR, RX_DATA (RX_PAR with the feature); bit counter 0..FL-1.
  - On the last bit, the full frame is latched into the write stage and the counter returns to 0.
  - sen=1 with counter!=0: frm_err=1, counter cleared, frame discarded, nothing written.
  - sen=1 with counter=0 is idle.
- Write stage (cycle C+1, where C is the edge sampling the last bit):
  - rb_rw=0, rb_a=addr, rb_d=data for exactly one cycle.
  - frame_cnt increments (saturating).
- Verify stage:
  - Cycle C+2: rb_rw=1, rb_a=addr held. rb_d holds its value until the next write.
  - Cycle C+3: compare rb_q with the stored data.
  - Mismatch sets vfy_err=1.
- rb_rw is 1 at all times other than the write cycle.
- Pipeline overlap: FL>=3, so write/verify of frame n never collides with the write of frame n+1.
- done:
  - Set on the C+3 compare of the frame that made frame_cnt reach NUM_FRAMES, only if that compare matched.
  - Sticky until rst.
  - After done=1, further frames are shifted in but ignored: no write, no count change.
- Errors:
  - Errors never block subsequent frames.
  - Exception: a frame with frm_err/par_err is not written and not counted.

Optional Feature:
- SBUS_PARITY_EN defined:
  - One extra bit follows the data; FL=ADDR_W+DATA_W+1.
  - Even parity over address+data+parity bit is required.
  - On failure: par_err=1; frame not written, not counted.
- SBUS_PARITY_EN undefined:
  - No parity bit; FL=ADDR_W+DATA_W.
  - par_err constant 0.

Test Plan:
- Reset, then one frame addr=3'b101, data=18'h2A5C3, sen low for 21 cycles -> at C+1: rb_rw=0, rb_a=5, rb_d=18'h2A5C3 for one cycle; frame_cnt=1; vfy_err=0 with a bank model.
- 8 back-to-back frames, addr 0..7, data=addr*18'h1111, sen low 168 cycles continuously -> 8 single-cycle writes spaced 21 cycles apart; frame_cnt=8; done=1 at C+3 of the 8th frame.
- sen rises after 10 bits of a frame -> frm_err=1; no write; frame_cnt unchanged. The next full frame writes normally.
- Bank model corrupts addr 2 read data (bit 0 flipped) -> vfy_err=1 at C+3 of that frame. After the 8th frame done=1, since frame 8 matches.
- 9th frame after done -> no rb_rw=0 pulse; frame_cnt stays 8. rst asserted mid-frame -> all outputs return to reset values next edge.
- With SBUS_PARITY_EN: frame addr=1, data=1, parity bit 1 (bad) -> par_err=1, no write. Same frame with parity 0 -> written.
